// File: rtl/core_lsu_if.sv
// Memory-side bus of the load/store unit: valid/ready request with byte strobes.
// The master drives the request fields; the slave answers with ready and read data.
interface core_lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic                mem_valid;
    logic                mem_ready;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [XLEN/8-1:0]   mem_wstrb;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN-1:0]     mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/core_lsu.sv
// Load/store unit: turns a single core access into one valid/ready memory transfer,
// with lane strobes, store replication, load extension, misalignment and timeout.
module core_lsu #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   rdata,
    output logic              err_misaligned,
    output logic              err_timeout,
    core_lsu_if.master        mem
);
    localparam int NB     = $clog2(XLEN / 8);
    localparam int STRB_W = XLEN / 8;
    localparam int CNT_W  = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [NB-1:0]     lane_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [STRB_W-1:0] mem_wstrb_q;
    logic [XLEN-1:0]   mem_wdata_q;

    logic [NB-1:0]     lane;
    logic [NB-1:0]     lane_mask;
    logic              misaligned;
    int                req_bytes;
    logic [STRB_W-1:0] strb_mask;
    logic [XLEN-1:0]   wdata_rep;
    logic [XLEN-1:0]   shifted;
    logic              sign;
    int                load_bits;
    logic [XLEN-1:0]   load_ext;

    assign lane = req_addr[NB-1:0];

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        req_bytes  = 1 << req_size;
        lane_mask  = NB'(req_bytes - 1);
        misaligned = ((lane & lane_mask) != '0) || (req_size == 2'd3 && XLEN == 32);
        strb_mask  = '0;
        wdata_rep  = '0;
        for (int i = 0; i < STRB_W; i++) begin
            strb_mask[i]          = (i < req_bytes);
            wdata_rep[8*i +: 8]   = req_wdata[8*(i % req_bytes) +: 8];
        end
    end

    // Load path: move the addressed lane to bit 0, then extend above the access width.
    always_comb begin
        shifted   = mem.mem_rdata >> {lane_q, 3'b000};
        load_bits = 8 << size_q;
        load_ext  = '0;
        case (size_q)
            2'd0:    sign = shifted[7];
            2'd1:    sign = shifted[15];
            2'd2:    sign = shifted[31];
            default: sign = shifted[XLEN-1];
        endcase
        for (int i = 0; i < XLEN; i++)
            load_ext[i] = (i < load_bits) ? shifted[i] : (sign & ~uns_q);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= S_IDLE;
            size_q         <= '0;
            uns_q          <= 1'b0;
            lane_q         <= '0;
            wait_cnt       <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wstrb_q    <= '0;
            mem_wdata_q    <= '0;
            rdata          <= '0;
            err_misaligned <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        size_q      <= req_size;
                        uns_q       <= req_unsigned;
                        lane_q      <= lane;
                        wait_cnt    <= '0;
                        mem_we_q    <= req_we;
                        mem_addr_q  <= {req_addr[ADDR_W-1:NB], NB'(0)};
                        mem_wstrb_q <= req_we ? (strb_mask << lane) : '0;
                        mem_wdata_q <= wdata_rep;
                        if (misaligned) begin
                            err_misaligned <= 1'b1;
                            state          <= S_DONE;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem.mem_ready) begin
                        rdata <= mem_we_q ? '0 : load_ext;
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        // Give up once this wait cycle brings the count to MAX_WAIT.
                        if (MAX_WAIT != 0 && int'(wait_cnt) + 1 >= MAX_WAIT) begin
                            err_timeout <= 1'b1;
                            state       <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    err_misaligned <= 1'b0;
                    err_timeout    <= 1'b0;
                    wait_cnt       <= '0;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign mem.mem_valid = (state == S_REQ);
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wstrb = mem_wstrb_q;
    assign mem.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_core_lsu.sv
// Directed bench for core_lsu (XLEN=32): one unit without timeout, one with MAX_WAIT=2,
// sharing request and memory-response stimulus; expected completions go through a queue.
module tb_core_lsu;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        ready = 1'b1;
    logic [31:0] rd_in = '0;

    logic        busy0, done0, mis0, to0;
    logic [31:0] rdata0;
    logic        busy2, done2, mis2, to2;
    logic [31:0] rdata2;

    core_lsu_if #(.XLEN(32), .ADDR_W(32)) m0 ();
    core_lsu_if #(.XLEN(32), .ADDR_W(32)) m2 ();

    assign m0.mem_ready = ready;
    assign m0.mem_rdata = rd_in;
    assign m2.mem_ready = ready;
    assign m2.mem_rdata = rd_in;

    core_lsu #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(0)) dut0 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy0), .done(done0), .rdata(rdata0),
        .err_misaligned(mis0), .err_timeout(to0), .mem(m0)
    );

    core_lsu #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(2)) dut2 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy2), .done(done2), .rdata(rdata2),
        .err_misaligned(mis2), .err_timeout(to2), .mem(m2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
        logic        to;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present a request for one cycle (cycle 0) and record its expected completion.
    task automatic start(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input exp_t e);
        sb.push_back(e);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        cyc          = 0;
        tick();
        req_valid    = 1'b0;
    endtask

    task automatic chk_bus(input string tag, input logic we, input logic [31:0] addr,
                           input logic [3:0] strb, input logic [31:0] wdata);
        check({tag, "_valid"}, 64'(m0.mem_valid), 64'(1));
        check({tag, "_we"},    64'(m0.mem_we),    64'(we));
        check({tag, "_addr"},  64'(m0.mem_addr),  64'(addr));
        check({tag, "_wstrb"}, 64'(m0.mem_wstrb), 64'(strb));
        check({tag, "_wdata"}, 64'(m0.mem_wdata), 64'(wdata));
    endtask

    // Wait (bounded) for done on the MAX_WAIT=0 unit and compare against the queue head.
    task automatic finish(input string tag);
        exp_t e;
        bit   got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (done0) got = 1'b1;
            else tick();
        end
        check({tag, "_done_seen"}, 64'(got), 64'(1));
        if (got) begin
            e = (sb.size() != 0) ? sb.pop_front() : '{rdata: 32'hx, mis: 1'bx, to: 1'bx, lat: 8'hff};
            check({tag, "_latency"}, 64'(cyc),    64'(e.lat));
            check({tag, "_rdata"},   64'(rdata0), 64'(e.rdata));
            check({tag, "_err_mis"}, 64'(mis0),   64'(e.mis));
            check({tag, "_err_to"},  64'(to0),    64'(e.to));
            tick();
            check({tag, "_done_pulse"}, 64'({done0, busy0}), 64'(0));
        end
    endtask

    initial begin
        // Reset state.
        repeat (2) tick();
        check("rst_ctrl",  64'({busy0, done0, mis0, to0}), 64'(0));
        check("rst_mem",   64'({m0.mem_valid, m0.mem_we, m0.mem_wstrb}), 64'(0));
        check("rst_addr",  64'(m0.mem_addr),  64'(0));
        check("rst_wdata", 64'(m0.mem_wdata), 64'(0));
        check("rst_rdata", 64'(rdata0),       64'(0));
        resetn = 1'b1;
        tick();
        check("idle_no_req", 64'({busy0, m0.mem_valid}), 64'(0));

        // Stores with immediate ready: done in cycle 2, rdata cleared.
        ready = 1'b1;
        start(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, '{32'h0, 1'b0, 1'b0, 8'd2});
        chk_bus("sw", 1'b1, 32'h100, 4'b1111, 32'hDEADBEEF);
        check("sw_busy", 64'(busy0), 64'(1));
        finish("sw");

        start(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5, '{32'h0, 1'b0, 1'b0, 8'd2});
        chk_bus("sb", 1'b1, 32'h100, 4'b1000, 32'hA5A5A5A5);
        finish("sb");

        start(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234ABCD, '{32'h0, 1'b0, 1'b0, 8'd2});
        chk_bus("sh", 1'b1, 32'h100, 4'b1100, 32'hABCDABCD);
        finish("sh");

        // Loads with sign and zero extension.
        rd_in = 32'h8001_1234;
        start(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, '{32'hFFFF8001, 1'b0, 1'b0, 8'd2});
        chk_bus("lh", 1'b0, 32'h100, 4'b0000, 32'h0);
        finish("lh");

        start(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, '{32'h00008001, 1'b0, 1'b0, 8'd2});
        finish("lhu");

        start(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, '{32'hFFFFFF80, 1'b0, 1'b0, 8'd2});
        finish("lb_hi");

        start(1'b0, 2'd0, 1'b0, 32'h101, 32'h0, '{32'h00000012, 1'b0, 1'b0, 8'd2});
        finish("lb_lane1");

        rd_in = 32'hCAFEF00D;
        start(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, '{32'hCAFEF00D, 1'b0, 1'b0, 8'd2});
        chk_bus("lw", 1'b0, 32'h104, 4'b0000, 32'h0);
        finish("lw");

        // Misaligned and illegal-size accesses: done in cycle 1, no memory cycle, rdata held.
        start(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, '{32'hCAFEF00D, 1'b1, 1'b0, 8'd1});
        check("mis_lw_valid", 64'(m0.mem_valid), 64'(0));
        finish("mis_lw");
        check("mis_lw_valid_after", 64'(m0.mem_valid), 64'(0));

        start(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, '{32'hCAFEF00D, 1'b1, 1'b0, 8'd1});
        check("mis_ld_valid", 64'(m0.mem_valid), 64'(0));
        finish("mis_ld");

        start(1'b1, 2'd1, 1'b0, 32'h101, 32'h5555, '{32'hCAFEF00D, 1'b1, 1'b0, 8'd1});
        check("mis_sh_valid", 64'(m0.mem_valid), 64'(0));
        finish("mis_sh");

        // Three wait cycles: unit 0 holds the bus for 4 cycles, unit 2 times out after 2.
        ready = 1'b0;
        rd_in = 32'h13579BDF;
        start(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, '{32'h13579BDF, 1'b0, 1'b0, 8'd5});
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) ready = 1'b1;
            chk_bus($sformatf("wait%0d", k), 1'b0, 32'h200, 4'b0000, 32'h0);
            check($sformatf("wait%0d_done0", k), 64'(done0), 64'(0));
            check($sformatf("wait%0d_to_valid", k), 64'(m2.mem_valid), 64'(k <= 2));
            check($sformatf("wait%0d_to_done", k),  64'(done2),        64'(k == 3));
            if (k == 3) begin
                check("to_err_timeout", 64'({to2, mis2}), 64'(2'b10));
                check("to_rdata_held",  64'(rdata2),      64'(32'hCAFEF00D));
            end
            tick();
        end
        finish("ld_wait");
        check("to_err_cleared", 64'({to2, done2, busy2}), 64'(0));

        // Asynchronous reset in the middle of REQ.
        ready = 1'b0;
        start(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, '{32'h0, 1'b0, 1'b0, 8'd0});
        chk_bus("pre_rst", 1'b0, 32'h100, 4'b0000, 32'h0);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_mid_valid", 64'({m0.mem_valid, m2.mem_valid}), 64'(0));
        check("rst_mid_busy",  64'({busy0, busy2}), 64'(0));
        void'(sb.pop_back());
        tick();
        check("rst_mid_nodone", 64'({done0, done2}), 64'(0));
        check("rst_mid_rdata",  64'(rdata0), 64'(0));
        resetn = 1'b1;
        tick();
        check("rst_rel_nodone", 64'({done0, busy0}), 64'(0));

        ready = 1'b1;
        rd_in = 32'h000000F0;
        start(1'b0, 2'd0, 1'b1, 32'h100, 32'h0, '{32'h000000F0, 1'b0, 1'b0, 8'd2});
        chk_bus("post_rst", 1'b0, 32'h100, 4'b0000, 32'h0);
        finish("post_rst");

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
